// File: rtl/atm_keypad_entry.sv
// rtl/atm_keypad_entry.sv - keypad front-end collecting account digit and 4-digit BCD PIN for the ATM
// Optional inactivity discard in S_PIN enabled by defining KEYPAD_TIMEOUT_EN.
module atm_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic [2:0]  digit_count,
    output logic        error,
    output logic        timeout
);

    typedef enum logic [1:0] {S_ACC, S_PIN, S_HOLD} state_t;

    if (2**TIMER_W <= TIMEOUT_CYCLES) begin : g_bad_timer_w
        $error("TIMER_W too narrow for TIMEOUT_CYCLES");
    end

    state_t      state_q;
    logic        out_valid_q;
    logic [3:0]  acc_q;
    logic [15:0] pin_q;
    logic [2:0]  cnt_q;
    logic        error_q;

    logic is_digit, is_clear, is_bs, is_enter;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_clear = key_valid && (key_code == 4'hA);
    assign is_bs    = key_valid && (key_code == 4'hB);
    assign is_enter = key_valid && (key_code == 4'hC);

`ifdef KEYPAD_TIMEOUT_EN
    logic               timeout_q;
    logic [TIMER_W-1:0] idle_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_ACC;
            out_valid_q <= 1'b0;
            acc_q       <= 4'h0;
            pin_q       <= 16'h0;
            cnt_q       <= 3'd0;
            error_q     <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
            timeout_q   <= 1'b0;
            idle_q      <= '0;
`endif
        end else begin
            error_q <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
            // Idle counter defaults to clear; only a keyless S_PIN cycle advances it.
            timeout_q <= 1'b0;
            idle_q    <= '0;
`endif
            case (state_q)
                S_ACC: begin
                    if (is_digit) begin
                        acc_q   <= key_code;
                        cnt_q   <= 3'd0;
                        pin_q   <= 16'h0;
                        state_q <= S_PIN;
                    end else if (is_enter) begin
                        error_q <= 1'b1;
                    end
                end
                S_PIN: begin
                    if (is_digit) begin
                        if (cnt_q != 3'd4) begin
                            pin_q <= {pin_q[11:0], key_code};
                            cnt_q <= cnt_q + 3'd1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end else if (is_bs) begin
                        if (cnt_q != 3'd0) begin
                            pin_q <= {4'h0, pin_q[15:4]};
                            cnt_q <= cnt_q - 3'd1;
                        end else begin
                            acc_q   <= 4'h0;
                            state_q <= S_ACC;
                        end
                    end else if (is_clear) begin
                        acc_q   <= 4'h0;
                        pin_q   <= 16'h0;
                        cnt_q   <= 3'd0;
                        state_q <= S_ACC;
                    end else if (is_enter) begin
                        if (cnt_q == 3'd4) begin
                            out_valid_q <= 1'b1;
                            state_q     <= S_HOLD;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
`ifdef KEYPAD_TIMEOUT_EN
                    else if (idle_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        acc_q     <= 4'h0;
                        pin_q     <= 16'h0;
                        cnt_q     <= 3'd0;
                        timeout_q <= 1'b1;
                        state_q   <= S_ACC;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    // Keys arriving here, even on the handshake edge, are dropped.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= 4'h0;
                        pin_q       <= 16'h0;
                        cnt_q       <= 3'd0;
                        state_q     <= S_ACC;
                    end
                end
                default: state_q <= S_ACC;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign acc_num     = acc_q;
    assign pin         = pin_q;
    assign digit_count = cnt_q;
    assign error       = error_q;
`ifdef KEYPAD_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule
